// File: rtl/invaes_pkg.sv
// Shared definitions for the inverse-AES key schedule: FSM state encoding,
// key-length derived sizes and the round-constant table.
package invaes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_SERVE  = 2'd3
  } ks_state_e;

  // Key length in 32-bit words (4/6/8).
  function automatic int nk_of(input int k);
    return k / 32;
  endfunction

  // Number of rounds (10/12/14).
  function automatic int nr_of(input int k);
    return (k / 32) + 6;
  endfunction

  // Total expanded words (44/52/60).
  function automatic int nw_of(input int k);
    return 4 * ((k / 32) + 7);
  endfunction

  // Round constant top byte for index 1..10; other indices never used.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/invaes_sbox.sv
// Forward AES S-box, purely combinational byte substitution.
module invaes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/invaes_key_schedule.sv
// AES key expansion that delivers round keys in decryption order (Nr..0)
// over a valid/ready handshake. One expanded word is produced per cycle into
// a register file; the file is then read four words at a time.
module invaes_key_schedule
  import invaes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K-1:0]   key,
  output logic           busy,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [127:0]   rk_data,
  output logic [3:0]     rk_round,
  output logic           rk_last
);

  localparam int NK = nk_of(K);
  localparam int NR = nr_of(K);
  localparam int NW = nw_of(K);

  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);
  localparam logic [5:0] LAST_I = 6'(NW - 1);
  localparam logic [3:0] NR_R   = 4'(NR);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("invaes_key_schedule: K must be 128, 192 or 256");
  end

  ks_state_e   r_state;
  ks_state_e   w_state_nxt;
  logic [5:0]  r_idx;    // word index i being written in EXPAND
  logic [2:0]  r_mod;    // i mod Nk, tracked incrementally
  logic [3:0]  r_rc;     // i / Nk, tracked incrementally (Rcon index)
  logic [3:0]  r_round;  // round key currently offered in SERVE
  logic [31:0] r_w [NW];

  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic [5:0]  w_base;

  assign w_prev   = r_w[r_idx - 6'd1];
  assign w_back   = r_w[r_idx - NK_W];
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    invaes_sbox u_sbox (
      .i_byte (w_sub_in[8*b +: 8]),
      .o_byte (w_sub_out[8*b +: 8])
    );
  end

  // Select the transformed predecessor word for the current position i.
  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub_out ^ {rcon_of(r_rc), 24'h000000};
    end else if (NK == 8 && r_mod == 3'd4) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new  = w_back ^ w_temp;
  assign w_base = {r_round, 2'b00};

  assign busy     = (r_state != ST_IDLE);
  assign rk_valid = (r_state == ST_SERVE);
  assign rk_round = r_round;
  assign rk_last  = rk_valid && (r_round == 4'd0);
  assign rk_data  = rk_valid ? {r_w[w_base], r_w[w_base + 6'd1],
                                r_w[w_base + 6'd2], r_w[w_base + 6'd3]} : 128'h0;

  // Next-state logic for IDLE -> LOAD -> EXPAND -> SERVE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (r_idx == LAST_I) w_state_nxt = ST_SERVE;
      ST_SERVE:  if (rk_ready && r_round == 4'd0) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: state, word index, Rcon tracking and served round.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= 6'd0;
      r_mod   <= 3'd0;
      r_rc    <= 4'd0;
      r_round <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_LOAD: begin
          r_idx <= NK_W;
          r_mod <= 3'd0;
          r_rc  <= 4'd1;
        end
        ST_EXPAND: begin
          r_idx <= r_idx + 6'd1;
          if (r_mod == NK_M1) begin
            r_mod <= 3'd0;
            r_rc  <= r_rc + 4'd1;
          end else begin
            r_mod <= r_mod + 3'd1;
          end
          if (r_idx == LAST_I) r_round <= NR_R;
        end
        ST_SERVE: begin
          if (rk_ready && r_round != 4'd0) r_round <= r_round - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Word store: key words on an accepted start, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start) begin
      for (int j = 0; j < NK; j++) r_w[j] <= key[K-1-32*j -: 32];
    end else if (r_state == ST_EXPAND) begin
      r_w[r_idx] <= w_new;
    end
  end

endmodule

// File: tb/tb_invaes_key_schedule.sv
// Directed bench for invaes_key_schedule: one instance per key length,
// a vector table of known schedules, plus stall, restart and reset sequences.
module tb_invaes_key_schedule;

  logic         clk = 1'b0;
  logic         reset, start, rk_ready;
  logic [255:0] key_bus;
  int           sel;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  logic         s0, s1, s2;
  logic         b0, b1, b2, v0, v1, v2, l0, l1, l2;
  logic [127:0] d0, d1, d2;
  logic [3:0]   r0, r1, r2;
  logic         m_busy, m_valid, m_last;
  logic [127:0] m_data;
  logic [3:0]   m_round;

  assign s0 = start && (sel == 0);
  assign s1 = start && (sel == 1);
  assign s2 = start && (sel == 2);

  invaes_key_schedule #(.K(128)) u_k128 (
    .clk(clk), .reset(reset), .start(s0), .key(key_bus[255:128]), .busy(b0),
    .rk_valid(v0), .rk_ready(rk_ready), .rk_data(d0), .rk_round(r0), .rk_last(l0));
  invaes_key_schedule #(.K(192)) u_k192 (
    .clk(clk), .reset(reset), .start(s1), .key(key_bus[255:64]), .busy(b1),
    .rk_valid(v1), .rk_ready(rk_ready), .rk_data(d1), .rk_round(r1), .rk_last(l1));
  invaes_key_schedule #(.K(256)) u_k256 (
    .clk(clk), .reset(reset), .start(s2), .key(key_bus), .busy(b2),
    .rk_valid(v2), .rk_ready(rk_ready), .rk_data(d2), .rk_round(r2), .rk_last(l2));

  always_comb begin
    m_busy = b0; m_valid = v0; m_last = l0; m_data = d0; m_round = r0;
    if (sel == 1) begin
      m_busy = b1; m_valid = v1; m_last = l1; m_data = d1; m_round = r1;
    end else if (sel == 2) begin
      m_busy = b2; m_valid = v2; m_last = l2; m_data = d2; m_round = r2;
    end
  end

  typedef struct {
    int           inst;
    logic [255:0] key;
    int           lat;
    int           nr;
    logic [127:0] rk_first;
    logic [127:0] rk_zero;
    int           pct;
    bit           extra;
    bit           full;
  } vec_t;

  vec_t         vt [5];
  logic [127:0] exp128 [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic run_vec(input vec_t v, input int tag);
    int           cyc, xfers, guard, exp_r;
    bit           stalled;
    logic [127:0] hold_d;
    logic [3:0]   hold_r;
    sel = v.inst; key_bus = v.key; rk_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0; cyc = 1;
    check($sformatf("v%0d_busy_start", tag), m_busy, 1);
    while (!m_valid && cyc < 200) begin
      if (v.extra && cyc == 10) begin start = 1'b1; key_bus = ~v.key; end
      tick(); start = 1'b0; cyc++;
      rk_ready = pick(v.pct);
    end
    check($sformatf("v%0d_latency", tag), cyc, v.lat);
    exp_r = v.nr; xfers = 0; guard = 0; stalled = 0; hold_d = '0; hold_r = '0;
    while (xfers < v.nr + 1 && guard < 400) begin
      guard++;
      if (!m_valid) begin
        check($sformatf("v%0d_valid_held", tag), m_valid, 1);
        break;
      end
      if (stalled) begin
        check($sformatf("v%0d_stall_data", tag), m_data, hold_d);
        check($sformatf("v%0d_stall_round", tag), m_round, hold_r);
      end
      check($sformatf("v%0d_round", tag), m_round, exp_r[3:0]);
      check($sformatf("v%0d_last_r%0d", tag, exp_r), m_last, (exp_r == 0));
      if (rk_ready) begin
        if (v.full)
          check($sformatf("v%0d_rk_r%0d", tag, exp_r), m_data, exp128[exp_r]);
        else if (exp_r == v.nr)
          check($sformatf("v%0d_rk_first", tag), m_data, v.rk_first);
        else if (exp_r == 0)
          check($sformatf("v%0d_rk_zero", tag), m_data, v.rk_zero);
        if (exp_r == 0 && v.extra) start = 1'b1;
        exp_r--; xfers++; stalled = 0;
      end else begin
        stalled = 1; hold_d = m_data; hold_r = m_round;
      end
      tick(); start = 1'b0;
      rk_ready = pick(v.pct);
    end
    check($sformatf("v%0d_xfers", tag), xfers, v.nr + 1);
    check($sformatf("v%0d_idle_valid", tag), m_valid, 0);
    check($sformatf("v%0d_idle_busy", tag), m_busy, 0);
    check($sformatf("v%0d_idle_last", tag), m_last, 0);
    repeat (3) tick();
    check($sformatf("v%0d_stay_idle", tag), m_busy, 0);
    rk_ready = 1'b1;
  endtask

  initial begin
    exp128[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    exp128[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    exp128[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    exp128[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    exp128[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    exp128[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    exp128[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    exp128[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    exp128[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    exp128[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    exp128[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vt[0] = '{inst: 0, key: 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000,
              lat: 42, nr: 10, rk_first: 128'h13111d7fe3944a17f307a78b4d2b30c5,
              rk_zero: 128'h000102030405060708090a0b0c0d0e0f, pct: 100, extra: 0, full: 1};
    vt[1] = '{inst: 0, key: 256'h2b7e151628aed2a6abf7158809cf4f3c00000000000000000000000000000000,
              lat: 42, nr: 10, rk_first: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              rk_zero: 128'h2b7e151628aed2a6abf7158809cf4f3c, pct: 100, extra: 0, full: 0};
    vt[2] = '{inst: 1, key: 256'h000102030405060708090a0b0c0d0e0f10111213141516170000000000000000,
              lat: 48, nr: 12, rk_first: 128'ha4970a331a78dc09c418c271e3a41d5d,
              rk_zero: 128'h000102030405060708090a0b0c0d0e0f, pct: 100, extra: 0, full: 0};
    vt[3] = '{inst: 2, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              lat: 54, nr: 14, rk_first: 128'h24fc79ccbf0979e9371ac23c6d68de36,
              rk_zero: 128'h000102030405060708090a0b0c0d0e0f, pct: 100, extra: 0, full: 0};
    vt[4] = vt[0];
    vt[4].pct = 30; vt[4].extra = 1;

    // Reset held together with start: reset must win.
    sel = 0; key_bus = vt[0].key; rk_ready = 1'b1; reset = 1'b1; start = 1'b1;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_busy", m_busy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_round", m_round, 0);
    check("rst_data", m_data, 0);
    check("rst_busy_all", {b1, b2, v1, v2}, 0);

    for (int t = 0; t < 5; t++) run_vec(vt[t], t);

    // Abandon a schedule at EXPAND cycle 20, then restart cleanly.
    sel = 0; key_bus = vt[0].key; rk_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    check("mid_busy", m_busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("post_rst_busy", m_busy, 0);
    check("post_rst_valid", m_valid, 0);
    check("post_rst_round", m_round, 0);
    tick();
    run_vec(vt[0], 5);

    // Abandon while serving (rk_ready held low), then restart.
    sel = 0; rk_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (45) tick();
    check("serve_valid", m_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("serve_rst_valid", m_valid, 0);
    check("serve_rst_data", m_data, 0);
    rk_ready = 1'b1;
    tick();
    run_vec(vt[0], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
